// File: rtl/paddle.sv
// Breakout paddle: keycode decode, per-frame move FSM, wall clamp. Accel/brake ramp when PADDLE_ACCEL_EN is defined.
// All outputs registered: one frame from key change to BarX change. There is no backpressure; one update per frame_clk edge.
module paddle #(
    parameter logic [9:0] X_START   = 10'd320,
    parameter logic [9:0] Y_POS     = 10'd460,
    parameter logic [9:0] HALF_W    = 10'd32,
    parameter logic [9:0] HALF_H    = 10'd4,
    parameter logic [9:0] X_MIN     = 10'd0,
    parameter logic [9:0] X_MAX     = 10'd639,
    parameter logic [3:0] MAX_SPEED = 4'd6
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       Ball_out,
    output logic [9:0] BarX,
    output logic [9:0] BarY,
    output logic [9:0] Bar_Sizex,
    output logic [9:0] Bar_Sizey,
    output logic [3:0] Bar_Speed,
    output logic       Bar_Wall
);

    typedef enum logic [1:0] {S_IDLE, S_MOVE_L, S_MOVE_R, S_BRAKE} state_t;

    localparam logic       DIR_L  = 1'b0;
    localparam logic       DIR_R  = 1'b1;
    localparam logic [9:0] X_LEFT  = X_MIN + HALF_W;
    localparam logic [9:0] X_RIGHT = X_MAX - HALF_W;

    state_t     r_state, w_state_next;
    logic       r_dir, w_dir_next;
    logic [3:0] r_speed, w_speed_next, w_speed_out;
    logic [9:0] r_x, w_x_next;
    logic       r_wall;
    logic       w_key_l, w_key_r;
    logic [10:0] w_x_ext, w_spd_ext;

    assign w_key_l = (keycode == 8'h04) || (keycode == 8'h50);
    assign w_key_r = (keycode == 8'h07) || (keycode == 8'h4F);

`ifdef PADDLE_ACCEL_EN
    logic       w_same_held, w_opp_held;
    logic [3:0] w_speed_inc, w_speed_dec;

    assign w_same_held = (r_dir == DIR_R) ? w_key_r : w_key_l;
    assign w_opp_held  = (r_dir == DIR_R) ? w_key_l : w_key_r;
    assign w_speed_inc = (r_speed >= MAX_SPEED) ? MAX_SPEED : r_speed + 4'd1;
    // Saturate so a brake entered from a clamped (speed 0) frame cannot wrap.
    assign w_speed_dec = (r_speed == 4'd0) ? 4'd0 : r_speed - 4'd1;
`endif

    always_comb begin : next_state
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_speed_next = r_speed;
`ifdef PADDLE_ACCEL_EN
        case (r_state)
            S_IDLE: begin
                w_speed_next = 4'd0;
                if (w_key_l) begin
                    w_state_next = S_MOVE_L;
                    w_dir_next   = DIR_L;
                    w_speed_next = 4'd1;
                end else if (w_key_r) begin
                    w_state_next = S_MOVE_R;
                    w_dir_next   = DIR_R;
                    w_speed_next = 4'd1;
                end
            end
            S_MOVE_L, S_MOVE_R: begin
                if (w_same_held) begin
                    w_speed_next = w_speed_inc;
                end else begin
                    w_state_next = S_BRAKE;
                    w_speed_next = w_speed_dec;
                end
            end
            S_BRAKE: begin
                if (w_same_held) begin
                    w_state_next = (r_dir == DIR_R) ? S_MOVE_R : S_MOVE_L;
                    w_speed_next = w_speed_inc;
                end else begin
                    w_speed_next = w_speed_dec;
                    if (w_speed_dec == 4'd0) begin
                        if (w_opp_held) begin
                            w_state_next = (r_dir == DIR_R) ? S_MOVE_L : S_MOVE_R;
                            w_dir_next   = ~r_dir;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_speed_next = 4'd0;
            end
        endcase
`else
        case (r_state)
            S_IDLE, S_MOVE_L, S_MOVE_R: begin
                if (w_key_l) begin
                    w_state_next = S_MOVE_L;
                    w_dir_next   = DIR_L;
                    w_speed_next = MAX_SPEED;
                end else if (w_key_r) begin
                    w_state_next = S_MOVE_R;
                    w_dir_next   = DIR_R;
                    w_speed_next = MAX_SPEED;
                end else begin
                    w_state_next = S_IDLE;
                    w_speed_next = 4'd0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_speed_next = 4'd0;
            end
        endcase
`endif
    end

    // Compare in 11 bits so BarX - speed can never underflow before the clamp decision.
    always_comb begin : move_clamp
        w_x_ext     = {1'b0, r_x};
        w_spd_ext   = {7'd0, w_speed_next};
        w_speed_out = w_speed_next;
        w_x_next    = r_x;
        if (w_dir_next == DIR_L) begin
            if (w_x_ext < ({1'b0, X_LEFT} + w_spd_ext)) begin
                w_x_next    = X_LEFT;
                w_speed_out = 4'd0;
            end else begin
                w_x_next = r_x - {6'd0, w_speed_next};
            end
        end else begin
            if ((w_x_ext + {1'b0, HALF_W} + w_spd_ext) > {1'b0, X_MAX}) begin
                w_x_next    = X_RIGHT;
                w_speed_out = 4'd0;
            end else begin
                w_x_next = r_x + {6'd0, w_speed_next};
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_dir   <= DIR_R;
            r_speed <= 4'd0;
            r_x     <= X_START;
            r_wall  <= 1'b0;
        end else if (Ball_out) begin
            r_state <= S_IDLE;
            r_speed <= 4'd0;
            r_x     <= X_START;
            r_wall  <= (X_START == X_LEFT) || (X_START == X_RIGHT);
        end else begin
            r_state <= w_state_next;
            r_dir   <= w_dir_next;
            r_speed <= w_speed_out;
            r_x     <= w_x_next;
            r_wall  <= (w_x_next == X_LEFT) || (w_x_next == X_RIGHT);
        end
    end

    assign BarX      = r_x;
    assign BarY      = Y_POS;
    assign Bar_Sizex = HALF_W;
    assign Bar_Sizey = HALF_H;
    assign Bar_Speed = r_speed;
    assign Bar_Wall  = r_wall;

endmodule

// File: tb/tb_paddle.sv
// Directed bench for paddle; expected tables follow the PADDLE_ACCEL_EN build setting.
module tb_paddle;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [7:0] keycode   = 8'h00;
    logic       Ball_out  = 1'b0;
    logic [9:0] BarX, BarY, Bar_Sizex, Bar_Sizey;
    logic [3:0] Bar_Speed;
    logic       Bar_Wall;

    int n_vec  = 0;
    int n_miss = 0;

    paddle dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .Ball_out  (Ball_out),
        .BarX      (BarX),
        .BarY      (BarY),
        .Bar_Sizex (Bar_Sizex),
        .Bar_Sizey (Bar_Sizey),
        .Bar_Speed (Bar_Speed),
        .Bar_Wall  (Bar_Wall)
    );

    always #5 frame_clk = ~frame_clk;

`ifdef PADDLE_ACCEL_EN
    int t2_spd [8] = '{1, 2, 3, 4, 5, 6, 6, 6};
    int t2_x   [8] = '{321, 323, 326, 330, 335, 341, 347, 353};
    int t3_spd [7] = '{5, 4, 3, 2, 1, 0, 0};
    int t3_x   [7] = '{358, 362, 365, 367, 368, 368, 368};
    int t4_spd [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int t4_x   [8] = '{321, 323, 326, 328, 329, 329, 328, 326};
    int t6_spd = 1;
    int t6_x   = 321;
`else
    int t2_spd [8] = '{6, 6, 6, 6, 6, 6, 6, 6};
    int t2_x   [8] = '{326, 332, 338, 344, 350, 356, 362, 368};
    int t3_spd [7] = '{0, 0, 0, 0, 0, 0, 0};
    int t3_x   [7] = '{368, 368, 368, 368, 368, 368, 368};
    int t4_spd [8] = '{6, 6, 6, 6, 6, 6, 6, 6};
    int t4_x   [8] = '{326, 332, 338, 332, 326, 320, 314, 308};
    int t6_spd = 6;
    int t6_x   = 326;
`endif
    logic [7:0] t4_key [8] = '{8'h07, 8'h07, 8'h07, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic frame();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
    endtask

    int ext;

    initial begin
        #12;
        chk("rst_x",     BarX,      320);
        chk("rst_y",     BarY,      460);
        chk("rst_sx",    Bar_Sizex, 32);
        chk("rst_sy",    Bar_Sizey, 4);
        chk("rst_spd",   Bar_Speed, 0);
        chk("rst_wall",  Bar_Wall,  0);
        Reset = 1'b0;

        // Hold right for 8 frames, then release.
        keycode = 8'h07;
        for (int i = 0; i < 8; i++) begin
            frame();
            chk($sformatf("hold_spd[%0d]", i), Bar_Speed, t2_spd[i]);
            chk($sformatf("hold_x[%0d]", i),   BarX,      t2_x[i]);
        end
        keycode = 8'h00;
        for (int i = 0; i < 7; i++) begin
            frame();
            chk($sformatf("rel_spd[%0d]", i), Bar_Speed, t3_spd[i]);
            chk($sformatf("rel_x[%0d]", i),   BarX,      t3_x[i]);
        end

        // Ramp right then press the opposite key.
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            keycode = t4_key[i];
            frame();
            chk($sformatf("rev_spd[%0d]", i), Bar_Speed, t4_spd[i]);
            chk($sformatf("rev_x[%0d]", i),   BarX,      t4_x[i]);
        end

        // Asynchronous reset while moving, checked before any edge.
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_x",    BarX,      320);
        chk("arst_y",    BarY,      460);
        chk("arst_sx",   Bar_Sizex, 32);
        chk("arst_sy",   Bar_Sizey, 4);
        chk("arst_spd",  Bar_Speed, 0);
        chk("arst_wall", Bar_Wall,  0);
        #1;
        Reset = 1'b0;

        // Left wall.
        keycode = 8'h50;
        frame();
        chk("lw_wall0", Bar_Wall, 0);
        ext = 1023;
        for (int i = 0; i < 80; i++) begin
            frame();
            if (int'(BarX) < ext) ext = int'(BarX);
        end
        chk("lw_min",  ext,       32);
        chk("lw_x",    BarX,      32);
        chk("lw_wall", Bar_Wall,  1);
        chk("lw_spd",  Bar_Speed, 0);

        // Right wall.
        keycode = 8'h00;
        pulse_reset();
        keycode = 8'h4F;
        ext = 0;
        for (int i = 0; i < 80; i++) begin
            frame();
            if (int'(BarX) > ext) ext = int'(BarX);
        end
        chk("rw_max",  ext,       607);
        chk("rw_x",    BarX,      607);
        chk("rw_wall", Bar_Wall,  1);
        chk("rw_spd",  Bar_Speed, 0);

        // Miss recentres, then motion restarts from IDLE.
        keycode = 8'h00;
        pulse_reset();
        keycode = 8'h07;
        for (int i = 0; i < 10; i++) frame();
        chk("miss_pre_spd", Bar_Speed, 6);
        Ball_out = 1'b1;
        frame();
        Ball_out = 1'b0;
        chk("miss_x",    BarX,      320);
        chk("miss_spd",  Bar_Speed, 0);
        chk("miss_wall", Bar_Wall,  0);
        frame();
        chk("post_spd", Bar_Speed, t6_spd);
        chk("post_x",   BarX,      t6_x);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/paddle.md
Name: paddle

Overview:
- Player paddle controller for Breakout.
- Decodes the keyboard keycode into left/right intent and runs a per-frame accelerate/brake state machine.
- Updates the paddle centre position once per frame with wall clamping.
- Produces the bar geometry (BarX, BarY, Bar_Sizex, Bar_Sizey) consumed by the ball block's collision logic and by the colour mapper; recentres when the ball block reports a miss (Ball_out).

Parameters:
- X_START, 320, paddle centre X after reset or miss
- Y_POS, 460, fixed paddle centre Y
- HALF_W, 32, paddle half-width driven on Bar_Sizex
- HALF_H, 4, paddle half-height driven on Bar_Sizey
- X_MIN, 0, leftmost screen column
- X_MAX, 639, rightmost screen column
- MAX_SPEED, 6, speed ceiling in pixels/frame (must be ≤ 15)

Ports:
- frame_clk  input  1  frame-rate clock (vsync); one update per rising edge
- Reset  input  1  asynchronous, active-high reset
- keycode  input  8  current USB HID keycode
- Ball_out  input  1  ball-missed flag from the ball block
- BarX  output  10  paddle centre X
- BarY  output  10  paddle centre Y (constant Y_POS)
- Bar_Sizex  output  10  HALF_W
- Bar_Sizey  output  10  HALF_H
- Bar_Speed  output  4  current speed magnitude
- Bar_Wall  output  1  high while BarX sits at a clamp limit

Behaviour:
- Reset (async, any time, dominates everything): BarX=X_START, speed=0, state=IDLE, Bar_Wall=0. BarY, Bar_Sizex and Bar_Sizey are constants.
- Key decode: L = keycode is 8'h04 or 8'h50; R = keycode is 8'h07 or 8'h4F; any other code means no key. L and R are never both true.
- States: IDLE, MOVE_L, MOVE_R, BRAKE. A direction register (dir) holds the last motion direction.
- Per edge, in order: (1) compute speed_next and state_next; (2) BarX moves by speed_next in dir_next; (3) clamp. All outputs are registered, so there is 1-frame latency from a key change to a BarX change.
- IDLE:
  - L: go to MOVE_L, speed 1.
  - R: go to MOVE_R, speed 1.
  - Otherwise: stay in IDLE, speed 0.
- MOVE_x:
  - Same key held: speed = min(speed+1, MAX_SPEED).
  - Key released or opposite key pressed: go to BRAKE, speed−1; dir is unchanged.
- BRAKE:
  - Speed decrements by 1 each frame while moving in dir.
  - Key matching dir: return to MOVE_dir, speed+1 (capped).
  - When speed reaches 0: go to MOVE_opposite if the opposite key is held (speed 1 on the following frame), else go to IDLE.
- Clamp (11-bit compare, no underflow):
  - Left clamp: moving left and BarX < X_MIN+HALF_W+speed_next. Set BarX = X_MIN+HALF_W (32), speed = 0.
  - Right clamp: moving right and BarX+HALF_W+speed_next > X_MAX. Set BarX = X_MAX−HALF_W (607), speed = 0.
  - State is not forced on a clamp. A held key re-ramps from 1 and re-clamps each frame, so the paddle stays pinned.
- Bar_Wall = (BarX==32) or (BarX==607), registered with BarX.
- Ball_out high at an edge overrides keys and state: BarX=X_START, speed=0, state=IDLE. Normal processing resumes the next edge.
- Speed is unsigned 4-bit. Position arithmetic is 10-bit unsigned and never wraps because of the clamp.

Optional Feature:
- Macro: PADDLE_ACCEL_EN.
- Defined: the accelerate/brake behaviour described above.
- Undefined:
  - Speed is MAX_SPEED on the first pressed frame.
  - Release goes straight to IDLE with speed 0.
  - The opposite key reverses immediately at MAX_SPEED.
  - The BRAKE state is never entered.
  - Clamping is unchanged.

Test Plan:
1. Reset mid-frame while moving → BarX=320, BarY=460, Bar_Sizex=32, Bar_Sizey=4, Bar_Speed=0, Bar_Wall=0 immediately, with no clock edge needed.
2. Hold 8'h07 for 8 frames from 320 → Bar_Speed 1,2,3,4,5,6,6,6; BarX 321,323,326,330,335,341,347,353.
3. Release keycode to 8'h00 after test 2 → Bar_Speed 5,4,3,2,1,0; BarX 358,362,365,367,368,368; then IDLE with BarX constant.
4. From BarX=353 at speed 3 moving right, hold 8'h04 → speeds 2,1,0 (BarX 355,356,356), then speed 1 with BarX 355 moving left.
5. Hold 8'h50 from 320 until the wall → BarX settles at 32, Bar_Wall=1, never below 32. Repeat with 8'h4F → BarX 607.
6. Ball_out=1 for one frame while moving right at speed 6 with the key held → BarX=320, speed 0. The next frame gives speed 1 and BarX 321. Rerun with PADDLE_ACCEL_EN undefined → first pressed frame gives speed 6, BarX 326.
